// File: rtl/four_bit_full_adder.sv
// Four-bit ripple-carry adder with combinational sum/carry/overflow outputs
// and a one-cycle registered copy of each, cleared by a synchronous reset.
module four_bit_full_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       ovf,
    output logic [3:0] sum_q,
    output logic       cout_q,
    output logic       ovf_q
);

    // carry[0] is cin, carry[1..3] are the internal ripple carries c1..c3,
    // carry[4] is the carry-out of the top cell
    logic [4:0] carry;

    assign carry[0] = cin;

    // Four 1-bit full-adder cells chained through carry[]
    for (genvar i = 0; i < 4; i++) begin : g_cell
        logic p;
        assign p            = a[i] ^ b[i];
        assign sum[i]       = p ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & p);
    end

    assign cout = carry[4];

    // Signed overflow: carry into the sign bit differs from carry out of it
    assign ovf = carry[3] ^ carry[4];

    // Registered copies of the adder outputs; reset clears them at the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Directed and exhaustive self-checking bench for four_bit_full_adder.
module tb_four_bit_full_adder;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       ovf_q;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    // Hand-computed vectors: a, b, cin -> sum, cout, ovf
    vec_t vecs [8];

    four_bit_full_adder dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] total;
        logic       exp_ovf;

        vecs[0] = '{a: 4'h0, b: 4'h0, cin: 1'b0, sum: 4'h0, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 4'h1, b: 4'h2, cin: 1'b0, sum: 4'h3, cout: 1'b0, ovf: 1'b0};
        vecs[2] = '{a: 4'hA, b: 4'h5, cin: 1'b1, sum: 4'h0, cout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 4'hF, b: 4'h1, cin: 1'b0, sum: 4'h0, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 4'hF, b: 4'hF, cin: 1'b1, sum: 4'hF, cout: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 4'h7, b: 4'h1, cin: 1'b0, sum: 4'h8, cout: 1'b0, ovf: 1'b1};
        vecs[6] = '{a: 4'h8, b: 4'h8, cin: 1'b0, sum: 4'h0, cout: 1'b1, ovf: 1'b1};
        vecs[7] = '{a: 4'h5, b: 4'h3, cin: 1'b0, sum: 4'h8, cout: 1'b0, ovf: 1'b1};

        // Step 1: reset with zero operands
        rst = 1'b1; a = 4'h0; b = 4'h0; cin = 1'b0;
        tick();
        check("reset_sum_q",  sum_q,  4'h0);
        check("reset_cout_q", cout_q, 1'b0);
        check("reset_ovf_q",  ovf_q,  1'b0);

        // Step 2: operand arrives while reset is held -> reset wins,
        // combinational outputs unaffected by reset
        a = 4'hF; b = 4'hF; cin = 1'b1;
        #1;
        check("rst_comb_sum",  sum,  4'hF);
        check("rst_comb_cout", cout, 1'b1);
        tick();
        check("rst_wins_sum_q",  sum_q,  4'h0);
        check("rst_wins_cout_q", cout_q, 1'b0);

        // Step 3: first edge with reset released picks up the operands
        rst = 1'b0;
        tick();
        check("rel_sum_q",  sum_q,  4'hF);
        check("rel_cout_q", cout_q, 1'b1);
        check("rel_ovf_q",  ovf_q,  1'b0);

        // Step 4: input change between edges only reaches registers at next edge
        a = 4'h7; b = 4'h1; cin = 1'b0;
        #2;
        check("mid_comb_sum",  sum,   4'h8);
        check("mid_comb_ovf",  ovf,   1'b1);
        check("mid_hold_sum_q", sum_q, 4'hF);
        check("mid_hold_ovf_q", ovf_q, 1'b0);
        tick();
        check("next_sum_q",  sum_q,  4'h8);
        check("next_cout_q", cout_q, 1'b0);
        check("next_ovf_q",  ovf_q,  1'b1);

        // Step 5: registered path then mid-operation reset
        a = 4'hF; b = 4'hF; cin = 1'b1;
        tick();
        check("reg_sum_q",  sum_q,  4'hF);
        check("reg_cout_q", cout_q, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_sum_q",  sum_q,  4'h0);
        check("midrst_cout_q", cout_q, 1'b0);
        check("midrst_ovf_q",  ovf_q,  1'b0);
        check("midrst_sum",    sum,    4'hF);
        check("midrst_cout",   cout,   1'b1);
        rst = 1'b0;

        // Step 6: directed vectors, combinational and registered
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            #1;
            check("dir_sum",  sum,  vecs[i].sum);
            check("dir_cout", cout, vecs[i].cout);
            check("dir_ovf",  ovf,  vecs[i].ovf);
            tick();
            check("dir_sum_q",  sum_q,  vecs[i].sum);
            check("dir_cout_q", cout_q, vecs[i].cout);
            check("dir_ovf_q",  ovf_q,  vecs[i].ovf);
        end

        // Step 7: exhaustive sweep of all 512 input combinations
        for (int v = 0; v < 512; v++) begin
            a   = v[8:5];
            b   = v[4:1];
            cin = v[0];
            total   = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
            exp_ovf = (v[8] == v[4]) && (total[3] != v[8]);
            #1;
            check("exh_sum_cout", {cout, sum}, total);
            check("exh_ovf",      ovf,         exp_ovf);
            tick();
            check("exh_reg", {ovf_q, cout_q, sum_q}, {exp_ovf, total});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_full_adder.md
FOUR_BIT_FULL_ADDER -- requirements
Module: four_bit_full_adder

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 4 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  SHALL be the clock; all registers update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 a  input  4  SHALL be addend A, unsigned; bit 3 is the MSB.
REQ-006 b  input  4  SHALL be addend B, unsigned.
REQ-007 cin  input  1  SHALL be the carry-in.
REQ-008 sum  output  4  SHALL be the combinational sum bits of a+b+cin.
REQ-009 cout  output  1  SHALL be the combinational carry-out of a+b+cin.
REQ-010 ovf  output  1  SHALL be the combinational two's-complement overflow flag.
REQ-011 sum_q  output  4  SHALL be the registered copy of sum.
REQ-012 cout_q  output  1  SHALL be the registered copy of cout.
REQ-013 ovf_q  output  1  SHALL be the registered copy of ovf.

Function
REQ-014 The adder SHALL be built as a ripple chain of four 1-bit full-adder cells with internal carries c1..c3.
REQ-015 Cell 0 SHALL take cin as its carry-in; cell 3's carry-out SHALL drive cout.
REQ-016 Each cell SHALL compute s_i = a_i ^ b_i ^ c_i and c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
REQ-017 {cout,sum} SHALL equal a + b + cin evaluated as a 5-bit unsigned result, for all 512 input combinations.
REQ-018 ovf SHALL equal c3 ^ cout, i.e. a[3]==b[3] and sum[3]!=a[3].
REQ-019 sum, cout and ovf SHALL be purely combinational: they depend only on a, b and cin, are independent of clk and rst, and settle within the same time step as an input change.
REQ-020 Each rising clk edge with rst=0 SHALL load sum_q<=sum, cout_q<=cout and ovf_q<=ovf, giving one-cycle latency.
REQ-021 Overflow of the unsigned result SHALL NOT saturate: sum wraps modulo 16 and cout carries the fifth bit (e.g. 1111+0001+0 -> sum 0000, cout 1).
REQ-022 An input change between clock edges SHALL affect the registered outputs only at the next rising edge.
REQ-023 The block SHALL contain no latches, and the registered outputs SHALL contain no X after the first reset edge.

Reset
REQ-024 When rst=1 at a rising clk edge, sum_q, cout_q and ovf_q SHALL become 0.
REQ-025 rst SHALL have no effect on the combinational outputs sum, cout and ovf.
REQ-026 When rst and a new operand arrive at the same edge, reset SHALL win; the registered outputs SHALL reflect the operands at the first edge with rst=0.
REQ-027 Asserting rst mid-operation SHALL clear the registered outputs at that edge, with no residual state.

Verification
REQ-028 Zero vector: a=0000, b=0000, cin=0 -> sum 0000, cout 0, ovf 0.
REQ-029 Simple add: a=0001, b=0010, cin=0 -> sum 0011, cout 0; a=1010, b=0101, cin=1 -> sum 0000, cout 1, ovf 0.
REQ-030 Carry boundary: a=1111, b=0001, cin=0 -> sum 0000, cout 1; a=1111, b=1111, cin=1 -> sum 1111, cout 1, ovf 0.
REQ-031 Signed overflow: a=0111, b=0001, cin=0 -> sum 1000, cout 0, ovf 1; a=1000, b=1000, cin=0 -> sum 0000, cout 1, ovf 1.
REQ-032 Registered path: apply a=1111, b=1111, cin=1 with rst=0 -> after one clk edge sum_q 1111, cout_q 1; assert rst for one edge -> sum_q 0000, cout_q 0, ovf_q 0 while sum stays 1111.
REQ-033 Exhaustive check: sweep all 512 combinations of a, b and cin -> {cout,sum} == a+b+cin, and ovf matches REQ-018 every vector.
